// File: rtl/hand_pkg.sv
// Shared types and helpers for the per-hand card scoring logic.
package hand_pkg;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} hand_state_t;

    localparam int unsigned CARD_ACE  = 1;
    localparam int unsigned CARD_KING = 13;

    function automatic logic is_legal_card(input int unsigned code);
        return (code >= CARD_ACE) && (code <= CARD_KING);
    endfunction

endpackage

// File: rtl/card_point_value.sv
// Combinational card-code decoder: point value plus legal-code flag.
module card_point_value
    import hand_pkg::*;
#(
    parameter int CARD_W   = 4,
    parameter int FACE_MIN = 10,
    parameter int VAL_W    = 4
) (
    input  logic [CARD_W-1:0] card,
    output logic [VAL_W-1:0]  val,
    output logic              legal
);

    localparam logic [CARD_W:0] FACE_V = (CARD_W + 1)'(FACE_MIN);

    // Truncation to VAL_W is safe: only codes below FACE_MIN (<= MOD) pass through.
    always_comb begin
        val   = ({1'b0, card} >= FACE_V) ? '0 : VAL_W'(card);
        legal = is_legal_card(32'(card));
    end

endmodule

// File: rtl/hand_score_accum.sv
// Per-hand card accumulator: valid/ready card intake, modulo running score,
// card count, natural detection and sticky error flags.
module hand_score_accum
    import hand_pkg::*;
#(
    parameter int CARD_W      = 4,
    parameter int MAX_CARDS   = 3,
    parameter int MOD         = 10,
    parameter int FACE_MIN    = 10,
    parameter int NATURAL_MIN = 8
) (
    input  logic                           slow_clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           card_valid,
    input  logic [CARD_W-1:0]              card,
    output logic                           card_ready,
    output logic [$clog2(MOD)-1:0]         score,
    output logic                           score_valid,
    output logic [$clog2(MAX_CARDS+1)-1:0] num_cards,
    output logic                           hand_full,
    output logic                           natural,
    output logic                           err_full,
    output logic                           err_bad
);

    localparam int SCORE_W = $clog2(MOD);
    localparam int NUM_W   = $clog2(MAX_CARDS + 1);

    localparam logic [SCORE_W:0] MOD_V = (SCORE_W + 1)'(MOD);
    localparam logic [SCORE_W:0] NAT_V = (SCORE_W + 1)'(NATURAL_MIN);
    localparam logic [NUM_W:0]   MAX_V = (NUM_W + 1)'(MAX_CARDS);
    localparam logic [NUM_W:0]   TWO_V = (NUM_W + 1)'(2);

    // Handshake: a card transfers on a rising edge where card_valid and
    // card_ready are both high and the code is legal; otherwise it is dropped.
    hand_state_t state, state_next;

    logic [SCORE_W-1:0] val;
    logic               legal;
    logic               accept;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] new_score;
    logic [NUM_W:0]     num_inc;
    logic               last_card;
    logic               two_cards;

    card_point_value #(
        .CARD_W   (CARD_W),
        .FACE_MIN (FACE_MIN),
        .VAL_W    (SCORE_W)
    ) u_point (
        .card  (card),
        .val   (val),
        .legal (legal)
    );

    always_comb begin
        card_ready = (state != FULL) && !clear;
        accept     = card_valid && card_ready && legal;
        sum        = {1'b0, score} + {1'b0, val};
        new_score  = (sum >= MOD_V) ? SCORE_W'(sum - MOD_V) : sum[SCORE_W-1:0];
        num_inc    = {1'b0, num_cards} + 1'b1;
        last_card  = (num_inc == MAX_V);
        two_cards  = (num_inc == TWO_V);
        hand_full  = ({1'b0, num_cards} == MAX_V);
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = last_card ? FULL : PARTIAL;
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            score       <= '0;
            score_valid <= 1'b0;
            num_cards   <= '0;
            natural     <= 1'b0;
            err_full    <= 1'b0;
            err_bad     <= 1'b0;
        end else begin
            // accept is already low under clear, so no pulse follows a clear.
            score_valid <= accept;
            if (clear) begin
                score     <= '0;
                num_cards <= '0;
                natural   <= 1'b0;
                err_full  <= 1'b0;
                err_bad   <= 1'b0;
            end else begin
                if (accept) begin
                    score     <= new_score;
                    num_cards <= num_inc[NUM_W-1:0];
                    if (two_cards && ({1'b0, new_score} >= NAT_V)) begin
                        natural <= 1'b1;
                    end
                end
                if (card_valid && (state == FULL)) begin
                    err_full <= 1'b1;
                end
                if (card_valid && card_ready && !legal) begin
                    err_bad <= 1'b1;
                end
            end
        end
    end

endmodule
